// File: rtl/serial_paralelo_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_paralelo_rx_pkg
// Description : Shared phy definitions: comma symbol, lock depth, rx states.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_paralelo_rx_pkg;

    localparam logic [7:0] PHY_COMMA          = 8'hBC;
    localparam int         LOCK_COUNT_DEFAULT = 4;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } rx_state_t;

endpackage : serial_paralelo_rx_pkg
`default_nettype wire

// File: rtl/serial_paralelo_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_paralelo_rx_if
// Description : Serial-in / parallel-out bundle of the phy receive end.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_paralelo_rx_if;

    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
    logic       byte_strobe;

    // master: the receiver itself; slave: the line driver / byte consumer
    modport master (
        input  data_in,
        output data_out,
        output valid_out,
        output active,
        output byte_strobe
    );

    modport slave (
        output data_in,
        input  data_out,
        input  valid_out,
        input  active,
        input  byte_strobe
    );

endinterface : serial_paralelo_rx_if
`default_nettype wire

// File: rtl/serial_paralelo_rx_comma_detect.sv
`default_nettype none
// ============================================================================
// Module      : serial_paralelo_rx_comma_detect
// Description : Flags when the byte completed this cycle equals the comma.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_paralelo_rx_comma_detect
    import serial_paralelo_rx_pkg::*;
#(
    parameter logic [7:0] COMMA = PHY_COMMA
) (
    input  wire logic [7:0] byte_word,
    output logic            is_comma
);

    assign is_comma = (byte_word == COMMA);

endmodule : serial_paralelo_rx_comma_detect
`default_nettype wire

// File: rtl/serial_paralelo_rx.sv
`default_nettype none
// ============================================================================
// Module      : serial_paralelo_rx
// Description : Comma-aligned serial receiver; locks after LOCK_COUNT commas.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_paralelo_rx
    import serial_paralelo_rx_pkg::*;
#(
    parameter logic [7:0] COMMA      = PHY_COMMA,
    parameter int         LOCK_COUNT = LOCK_COUNT_DEFAULT
) (
    input  wire logic              clk_32f,
    input  wire logic              reset,
    serial_paralelo_rx_if.master   bus
);

    rx_state_t  r_state, w_state_nxt;
    // Only the seven most recent bits are kept; the eighth is data_in itself.
    logic [6:0] r_sr;
    logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
    logic [3:0] r_bc_cnt, w_bc_cnt_nxt;
    logic [7:0] r_data_out, w_data_out_nxt;
    logic       r_valid_out, w_valid_out_nxt;
    logic       r_active, w_active_nxt;
    logic       r_byte_strobe, w_byte_strobe_nxt;

    logic [7:0] w_byte_word;
    logic       w_is_comma;
    logic [3:0] w_bc_inc;

    assign w_byte_word = {r_sr, bus.data_in};
    assign w_bc_inc    = r_bc_cnt + 4'd1;

    serial_paralelo_rx_comma_detect #(
        .COMMA     (COMMA)
    ) u_comma_detect (
        .byte_word (w_byte_word),
        .is_comma  (w_is_comma)
    );

    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            r_state       <= SEARCH;
            r_sr          <= 7'd0;
            r_bit_cnt     <= 3'd0;
            r_bc_cnt      <= 4'd0;
            r_data_out    <= 8'h00;
            r_valid_out   <= 1'b0;
            r_active      <= 1'b0;
            r_byte_strobe <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_sr          <= w_byte_word[6:0];
            r_bit_cnt     <= w_bit_cnt_nxt;
            r_bc_cnt      <= w_bc_cnt_nxt;
            r_data_out    <= w_data_out_nxt;
            r_valid_out   <= w_valid_out_nxt;
            r_active      <= w_active_nxt;
            r_byte_strobe <= w_byte_strobe_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_bit_cnt_nxt     = r_bit_cnt;
        w_bc_cnt_nxt      = r_bc_cnt;
        w_data_out_nxt    = r_data_out;
        w_valid_out_nxt   = r_valid_out;
        w_active_nxt      = r_active;
        w_byte_strobe_nxt = 1'b0;

        case (r_state)
            SEARCH: begin
                // A comma at any bit offset fixes the byte boundary here.
                if (w_is_comma) begin
                    w_bit_cnt_nxt     = 3'd0;
                    w_bc_cnt_nxt      = 4'd1;
                    w_byte_strobe_nxt = 1'b1;
                    if (LOCK_COUNT == 1) begin
                        w_state_nxt  = ACTIVE;
                        w_active_nxt = 1'b1;
                    end else begin
                        w_state_nxt  = ALIGN;
                    end
                end
            end

            ALIGN: begin
                w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    w_byte_strobe_nxt = 1'b1;
                    if (w_is_comma) begin
                        w_bc_cnt_nxt = w_bc_inc;
                        if (w_bc_inc == 4'(LOCK_COUNT)) begin
                            w_state_nxt  = ACTIVE;
                            w_active_nxt = 1'b1;
                        end
                    end else begin
                        // False comma or slipped boundary: start over.
                        w_state_nxt  = SEARCH;
                        w_bc_cnt_nxt = 4'd0;
                    end
                end
            end

            ACTIVE: begin
                w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    w_byte_strobe_nxt = 1'b1;
                    if (w_is_comma) begin
                        w_data_out_nxt  = 8'h00;
                        w_valid_out_nxt = 1'b0;
                    end else begin
                        w_data_out_nxt  = w_byte_word;
                        w_valid_out_nxt = 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = SEARCH;
            end
        endcase
    end

    assign bus.data_out    = r_data_out;
    assign bus.valid_out   = r_valid_out;
    assign bus.active      = r_active;
    assign bus.byte_strobe = r_byte_strobe;

endmodule : serial_paralelo_rx
`default_nettype wire

// File: tb/tb_serial_paralelo_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_paralelo_rx
// Description : Directed self-checking bench for the phy serial receiver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_paralelo_rx;

    logic clk_32f = 1'b0;
    logic reset   = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_data   = 8'h00;
    logic       exp_valid  = 1'b0;
    logic       exp_active = 1'b0;

    serial_paralelo_rx_if bus ();

    serial_paralelo_rx #(
        .COMMA      (8'hBC),
        .LOCK_COUNT (4)
    ) dut (
        .clk_32f (clk_32f),
        .reset   (reset),
        .bus     (bus.master)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one bit, let the active edge sample it, then observe 1 time unit later.
    task automatic step(input logic b);
        bus.data_in = b;
        @(posedge clk_32f);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic exp_strobe);
        check({tag, ".strobe"}, {7'd0, bus.byte_strobe}, {7'd0, exp_strobe});
        check({tag, ".data"},   bus.data_out, exp_data);
        check({tag, ".valid"},  {7'd0, bus.valid_out}, {7'd0, exp_valid});
        check({tag, ".active"}, {7'd0, bus.active}, {7'd0, exp_active});
    endtask

    // Loose bits that never complete an aligned byte.
    task automatic send_bits(input string tag, input logic [7:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            step(bits[i]);
            check_outputs(tag, 1'b0);
        end
    endtask

    // One aligned byte MSB first; new output expectations take effect on its last bit.
    task automatic send_byte(input string tag, input logic [7:0] b,
                             input logic [7:0] nd, input logic nv, input logic na);
        for (int i = 7; i >= 0; i--) begin
            step(b[i]);
            if (i == 0) begin
                exp_data   = nd;
                exp_valid  = nv;
                exp_active = na;
                check_outputs(tag, 1'b1);
            end else begin
                check_outputs(tag, 1'b0);
            end
        end
    endtask

    initial begin
        bus.data_in = 1'b0;

        // Reset held with random line activity
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'($urandom));
            check_outputs("reset", 1'b0);
        end
        reset = 1'b1;

        // Lock: three idle bits then four aligned commas
        send_bits("pre", 8'h00, 3);
        send_byte("lock_c1", 8'hBC, 8'h00, 1'b0, 1'b0);
        send_byte("lock_c2", 8'hBC, 8'h00, 1'b0, 1'b0);
        send_byte("lock_c3", 8'hBC, 8'h00, 1'b0, 1'b0);
        send_byte("lock_c4", 8'hBC, 8'h00, 1'b0, 1'b1);

        // Data in ACTIVE
        send_byte("data_a5", 8'hA5, 8'hA5, 1'b1, 1'b1);
        send_byte("data_3c", 8'h3C, 8'h3C, 1'b1, 1'b1);
        send_byte("data_bc", 8'hBC, 8'h00, 1'b0, 1'b1);

        // Reset mid-byte: partial byte discarded, outputs cleared
        send_bits("partial", 8'b0000_0101, 3);
        reset = 1'b0;
        step(1'($urandom));
        exp_data   = 8'h00;
        exp_valid  = 1'b0;
        exp_active = 1'b0;
        check_outputs("midreset", 1'b0);
        reset = 1'b1;

        // False lock: two commas then a non-comma drops back to SEARCH
        send_byte("false_c1", 8'hBC, 8'h00, 1'b0, 1'b0);
        send_byte("false_c2", 8'hBC, 8'h00, 1'b0, 1'b0);
        send_byte("false_55", 8'h55, 8'h00, 1'b0, 1'b0);

        // Full re-acquisition needs four fresh commas
        send_byte("relock_c1", 8'hBC, 8'h00, 1'b0, 1'b0);
        send_byte("relock_c2", 8'hBC, 8'h00, 1'b0, 1'b0);
        send_byte("relock_c3", 8'hBC, 8'h00, 1'b0, 1'b0);
        send_byte("relock_c4", 8'hBC, 8'h00, 1'b0, 1'b1);

        // Transmitter-style valid/idle/valid sequence
        send_byte("tx_01", 8'h01, 8'h01, 1'b1, 1'b1);
        send_byte("tx_bc", 8'hBC, 8'h00, 1'b0, 1'b1);
        send_byte("tx_ff", 8'hFF, 8'hFF, 1'b1, 1'b1);

        // Unaligned comma pattern inside data is ignored once ACTIVE
        send_byte("in_5e", 8'h5E, 8'h5E, 1'b1, 1'b1);
        send_byte("in_40", 8'h40, 8'h40, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_serial_paralelo_rx
`default_nettype wire
